// File: rtl/isqrt_rr_sched_pkg.sv
// Shared defaults and the tag-pipe record for the round-robin isqrt scheduler.
package isqrt_sched_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ISQRT_LAT = DEF_WIDTH / 2;

  typedef struct packed {
    logic                 vld;
    logic [DEF_N_REQ-1:0] tag;
  } sched_tag_t;

endpackage

// File: rtl/isqrt_rr_sched_if.sv
// Requester-facing bundle: operand handshake, routed result and occupancy count.
interface isqrt_rr_sched_if
  import isqrt_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(DEF_ISQRT_LAT + 1)
);

  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ-1:0]       req_rdy;
  logic [N_REQ-1:0]       rsp_vld;
  logic [WIDTH-1:0]       rsp_y;
  logic [CNT_W-1:0]       in_flight;

  modport master (
    output req_vld, req_x,
    input  req_rdy, rsp_vld, rsp_y, in_flight
  );

  modport slave (
    input  req_vld, req_x,
    output req_rdy, rsp_vld, rsp_y, in_flight
  );

endinterface

// File: rtl/isqrt_rr_sched_isqrt.sv
// Fully pipelined integer square root: one result bit per stage, WIDTH/2 stages.
module isqrt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [WIDTH-1:0] x,
  output logic             y_vld,
  output logic [WIDTH-1:0] y
);

  localparam int H  = WIDTH / 2;
  localparam int RW = H + 2;

  logic [H-1:0]     vld_q;
  logic [H-1:0]     stage_vld_in;
  logic [H-1:0]     rem_q  [H];
  logic [H-1:0]     root_q [H];
  logic [WIDTH-1:0] xs_q   [H];
  logic [H-1:0]     rem_d  [H];
  logic [H-1:0]     root_d [H];
  logic [WIDTH-1:0] xs_d   [H];

  // Restoring digit-by-digit step: bring down two operand bits, try root*4+1.
  function automatic void sqrt_step(
    input  logic [H-1:0]     rem_in,
    input  logic [H-1:0]     root_in,
    input  logic [WIDTH-1:0] xs_in,
    output logic [H-1:0]     rem_o,
    output logic [H-1:0]     root_o,
    output logic [WIDTH-1:0] xs_o
  );
    logic [RW-1:0] rem_sh;
    logic [RW-1:0] trial;
    rem_sh = {rem_in, xs_in[WIDTH-1 -: 2]};
    trial  = {root_in, 2'b01};
    if (rem_sh >= trial) begin
      rem_o  = H'(rem_sh - trial);
      root_o = {root_in[H-2:0], 1'b1};
    end else begin
      rem_o  = H'(rem_sh);
      root_o = {root_in[H-2:0], 1'b0};
    end
    xs_o = {xs_in[WIDTH-3:0], 2'b00};
  endfunction

  assign stage_vld_in = {vld_q[H-2:0], x_vld};

  always_comb begin
    sqrt_step('0, '0, x, rem_d[0], root_d[0], xs_d[0]);
    for (int k = 1; k < H; k++) begin
      sqrt_step(rem_q[k-1], root_q[k-1], xs_q[k-1], rem_d[k], root_d[k], xs_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= stage_vld_in;
  end

  // Data stages only load behind a valid token, so idle slots do not toggle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < H; k++) begin
      if (stage_vld_in[k]) begin
        rem_q[k]  <= rem_d[k];
        root_q[k] <= root_d[k];
        xs_q[k]   <= xs_d[k];
      end
    end
  end

  assign y_vld = vld_q[H-1];
  assign y     = WIDTH'(root_q[H-1]);

endmodule

// File: rtl/isqrt_rr_sched_shreg.sv
// Delay line with a resettable valid chain and a non-reset, valid-gated data chain.
module shift_register_with_valid #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[DEPTH-2:0], in_vld};
  end

  always_ff @(posedge clk) begin
    if (in_vld) data_q[0] <= in_data;
    for (int k = 1; k < DEPTH; k++) begin
      if (vld_q[k-1]) data_q[k] <= data_q[k-1];
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/isqrt_rr_sched.sv
// Round-robin front end sharing one pipelined isqrt; a tag pipe routes results home.
module isqrt_rr_sched
  import isqrt_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ISQRT_LAT = DEF_ISQRT_LAT
) (
  input logic             clk,
  input logic             rst,
  isqrt_rr_sched_if.slave bus
);

  localparam int                 PTR_W   = $clog2(N_REQ);
  localparam int                 CNT_W   = $clog2(ISQRT_LAT + 1);
  localparam logic [PTR_W:0]     N_REQ_W = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0]   LAST    = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] grant_idx;
  logic             issue;
  logic [WIDTH-1:0] x_sel;
  logic [WIDTH-1:0] x_hold_q;
  logic             y_vld;
  logic [WIDTH-1:0] y;
  logic             sr_vld;
  logic [N_REQ-1:0] sr_tag;
  sched_tag_t       tag_in;
  sched_tag_t       tag_out;
  logic [CNT_W-1:0] in_flight_q;

  // First valid requester at or after ptr, wrapping; nothing is granted during reset.
  always_comb begin
    logic [PTR_W:0] idx;
    logic           found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    if (!rst) begin
      for (int off = 0; off < N_REQ; off++) begin
        idx = {1'b0, ptr_q} + (PTR_W + 1)'(off);
        if (idx >= N_REQ_W) idx = idx - N_REQ_W;
        if (!found && bus.req_vld[idx[PTR_W-1:0]]) begin
          grant[idx[PTR_W-1:0]] = 1'b1;
          grant_idx             = idx[PTR_W-1:0];
          found                 = 1'b1;
        end
      end
    end
  end

  assign issue = |grant;

  always_ff @(posedge clk) begin
    if (rst)        ptr_q <= '0;
    else if (issue) ptr_q <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
  end

  // Operand mux falls back to the last issued value so the isqrt input stays quiet when idle.
  always_comb begin
    x_sel = x_hold_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) x_sel = bus.req_x[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (issue) x_hold_q <= x_sel;
  end

  isqrt #(
    .WIDTH (WIDTH)
  ) u_isqrt (
    .clk   (clk),
    .rst   (rst),
    .x_vld (issue),
    .x     (x_sel),
    .y_vld (y_vld),
    .y     (y)
  );

  assign tag_in = '{vld: issue, tag: grant};

  shift_register_with_valid #(
    .WIDTH (N_REQ),
    .DEPTH (ISQRT_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (tag_in.vld),
    .in_data  (tag_in.tag),
    .out_vld  (sr_vld),
    .out_data (sr_tag)
  );

  assign tag_out = {sr_vld, sr_tag};

  always_ff @(posedge clk) begin
    if (rst)                 in_flight_q <= '0;
    else if (issue && !y_vld) in_flight_q <= in_flight_q + 1'b1;
    else if (!issue && y_vld) in_flight_q <= in_flight_q - 1'b1;
  end

  assign bus.req_rdy   = grant;
  assign bus.rsp_vld   = tag_out.tag & {N_REQ{y_vld}};
  assign bus.rsp_y     = y;
  assign bus.in_flight = in_flight_q;

  // The isqrt valid chain and the tag valid chain must stay in lockstep.
  a_tag_matches_isqrt: assert property (@(posedge clk) disable iff (rst) y_vld == tag_out.vld);
  a_in_flight_bounded: assert property (@(posedge clk) disable iff (rst) in_flight_q <= CNT_W'(ISQRT_LAT));

endmodule

// File: tb/tb_isqrt_rr_sched.sv
// Randomised bench for isqrt_rr_sched with a cycle-indexed arbitration/response model.
module tb_isqrt_rr_sched;
  import isqrt_sched_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 16;
  localparam int CW  = $clog2(LAT + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  isqrt_rr_sched_if #(.N_REQ(N), .WIDTH(W), .CNT_W(CW)) bus ();

  isqrt_rr_sched #(.N_REQ(N), .WIDTH(W), .ISQRT_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int          mptr = 0;
  int          outstanding = 0;
  int          cyc = 0;
  int          exp_req [int];
  logic [31:0] exp_y   [int];

  bit          log_en = 0;
  int          grant_log [$];
  int          rsp_req_log [$];
  logic [31:0] rsp_y_log [$];
  bit          gap_en = 0;
  int          gap = 0;
  int          max_gap = 0;
  bit          spur_en = 0;
  int          spur_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] vld, input logic [N*W-1:0] xs);
    bus.req_vld = vld;
    bus.req_x   = xs;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] isqrt_model(input logic [31:0] x);
    longint r;
    longint xl;
    xl = longint'(x);
    r  = longint'($sqrt(real'(xl)));
    while (r * r > xl) r--;
    while ((r + 1) * (r + 1) <= xl) r++;
    return 32'(r);
  endfunction

  function automatic logic [N*W-1:0] rand_xs();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: rotate-from-pointer grant, results due LAT cycles after the grant cycle.
  initial begin
    int          g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [31:0] xv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      g       = -1;
      exp_rdy = '0;
      if (!rst) begin
        for (int off = 0; off < N; off++) begin
          if (bus.req_vld[(mptr + off) % N]) begin
            g = (mptr + off) % N;
            break;
          end
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      checkOutput("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));

      exp_rv = '0;
      if (exp_req.exists(cyc)) exp_rv[exp_req[cyc]] = 1'b1;
      checkOutput("rsp_vld", 64'(bus.rsp_vld), 64'(exp_rv));
      if (exp_rv != '0) checkOutput("rsp_y", 64'(bus.rsp_y), 64'(exp_y[cyc]));
      checkOutput("in_flight", 64'(bus.in_flight), 64'(outstanding));

      if (log_en) begin
        for (int i = 0; i < N; i++) begin
          if (bus.req_rdy[i]) grant_log.push_back(i);
          if (bus.rsp_vld[i]) begin
            rsp_req_log.push_back(i);
            rsp_y_log.push_back(bus.rsp_y);
          end
        end
      end
      if (gap_en) begin
        if (bus.req_rdy[2]) gap = 0;
        else gap++;
        if (gap > max_gap) max_gap = gap;
      end
      if (spur_en && bus.rsp_vld != '0) spur_cnt++;

      if (rst) begin
        exp_req.delete();
        exp_y.delete();
        mptr        = 0;
        outstanding = 0;
      end else begin
        if (exp_rv != '0) begin
          outstanding--;
          exp_req.delete(cyc);
          exp_y.delete(cyc);
        end
        if (g >= 0) begin
          xv                 = bus.req_x[g*W +: W];
          exp_req[cyc + LAT] = g;
          exp_y[cyc + LAT]   = isqrt_model(xv);
          mptr               = (g + 1) % N;
          outstanding++;
        end
      end
      cyc++;
    end
  end

  initial begin
    logic [N-1:0] vld;

    rst         = 1'b1;
    bus.req_vld = '0;
    bus.req_x   = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.req_vld = '1;
    #1;
    checkOutput("reset_rdy", 64'(bus.req_rdy), 64'd0);
    checkOutput("reset_rsp_vld", 64'(bus.rsp_vld), 64'd0);
    checkOutput("reset_in_flight", 64'(bus.in_flight), 64'd0);
    bus.req_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single request");
    applyStimulus(4'b0001, {96'd0, 32'd16});
    checkOutput("single_in_flight_up", 64'(bus.in_flight), 64'd1);
    bus.req_vld = '0;
    wait_cycles(LAT - 1);
    checkOutput("single_rsp_vld", 64'(bus.rsp_vld), 64'b0001);
    checkOutput("single_rsp_y", 64'(bus.rsp_y), 64'd4);
    wait_cycles(1);
    checkOutput("single_in_flight_down", 64'(bus.in_flight), 64'd0);

    $display("[TB] all four requesters");
    rst = 1'b1;
    applyStimulus('0, '0);
    rst    = 1'b0;
    log_en = 1'b1;
    repeat (8) applyStimulus(4'b1111, {32'd16, 32'd9, 32'd4, 32'd1});
    repeat (LAT + 2) applyStimulus('0, '0);
    log_en = 1'b0;
    checkOutput("rr_grant_count", 64'(grant_log.size()), 64'd8);
    checkOutput("rr_rsp_count", 64'(rsp_req_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("rr_grant_order", 64'(grant_log[i]), 64'(i % 4));
      checkOutput("rr_rsp_route", 64'(rsp_req_log[i]), 64'(i % 4));
      checkOutput("rr_rsp_y", 64'(rsp_y_log[i]), 64'((i % 4) + 1));
    end

    $display("[TB] fairness");
    gap     = 0;
    max_gap = 0;
    gap_en  = 1'b1;
    repeat (60) applyStimulus({1'b0, 1'b1, 2'($urandom)}, rand_xs());
    gap_en = 1'b0;
    checkOutput("fair_gap_within_n", 64'(max_gap < N), 64'd1);
    repeat (LAT + 2) applyStimulus('0, rand_xs());

    $display("[TB] sparse random traffic");
    repeat (400) begin
      for (int i = 0; i < N; i++) vld[i] = ($urandom_range(3) == 0);
      applyStimulus(vld, rand_xs());
    end
    repeat (LAT + 2) applyStimulus('0, rand_xs());

    $display("[TB] reset mid-stream");
    repeat (10) applyStimulus('1, rand_xs());
    rst = 1'b1;
    applyStimulus('1, rand_xs());
    rst      = 1'b0;
    spur_cnt = 0;
    spur_en  = 1'b1;
    repeat (LAT + 4) applyStimulus('0, rand_xs());
    spur_en = 1'b0;
    checkOutput("reset_drops_inflight", 64'(spur_cnt), 64'd0);
    bus.req_vld = '1;
    #1;
    checkOutput("ptr_after_reset", 64'(bus.req_rdy), 64'b0001);
    @(posedge clk);
    #1;
    applyStimulus(4'b0010, {64'd0, 32'd100, 32'd0});
    bus.req_vld = '0;
    wait_cycles(LAT - 1);
    checkOutput("post_reset_rsp_vld", 64'(bus.rsp_vld), 64'b0010);
    checkOutput("post_reset_rsp_y", 64'(bus.rsp_y), 64'd10);

    $display("[TB] boundary operands");
    applyStimulus(4'b1000, {32'd0, 96'd0});
    applyStimulus(4'b1000, {32'hFFFF_FFFF, 96'd0});
    bus.req_vld = '0;
    wait_cycles(LAT - 2);
    checkOutput("bound_zero_vld", 64'(bus.rsp_vld), 64'b1000);
    checkOutput("bound_zero_y", 64'(bus.rsp_y), 64'd0);
    wait_cycles(1);
    checkOutput("bound_max_vld", 64'(bus.rsp_vld), 64'b1000);
    checkOutput("bound_max_y", 64'(bus.rsp_y), 64'd65535);
    repeat (4) applyStimulus('0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
